// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch request/response, preload and counter signals of the instruction-memory responder
//
// Purpose: bundles every non-clock, non-reset signal of imem_responder.
// Signals:
//   imemreq_val / imemreq_addr      fetch request (byte address), no backpressure
//   imemresp_val / _data / _err     fixed-latency fetch response
//   init_wen / init_addr / init_data preload write port
//   req_count                       accepted-request counter (wrapping)
// Modports:
//   master - processor / loader side (drives requests and preloads)
//   slave  - responder side (drives responses and the counter)

interface imem_responder_if;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        imemresp_err;
  logic        init_wen;
  logic [31:0] init_addr;
  logic [31:0] init_data;
  logic [15:0] req_count;

  modport master (
    output imemreq_val, imemreq_addr, init_wen, init_addr, init_data,
    input  imemresp_val, imemresp_data, imemresp_err, req_count
  );

  modport slave (
    input  imemreq_val, imemreq_addr, init_wen, init_addr, init_data,
    output imemresp_val, imemresp_data, imemresp_err, req_count
  );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - word-addressed instruction store with a fixed-latency fetch response pipeline
//
// Purpose: answers one fetch request per cycle from a WORDS x 32 instruction
// store. The store is read combinationally in the request cycle and the
// result travels through a LATENCY-deep shift pipeline to the outputs.
// Parameters:
//   WORDS   - store depth in words (power of two, 16..4096)
//   LATENCY - request-to-response delay in cycles (1..4)
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (clears pipeline and counter only)
//   imem - imem_responder_if slave modport (request, response, preload, counter)

module imem_responder #(
  parameter int WORDS   = 256,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  imem_responder_if.slave  imem
);

  localparam int AW = $clog2(WORDS);

  // Store is intentionally not reset: programs survive a processor reset.
  logic [31:0] r_store [WORDS];

  logic [LATENCY-1:0]       r_val;
  logic [LATENCY-1:0]       r_err;
  logic [LATENCY-1:0][31:0] r_data;
  logic [15:0]              r_count;

  logic [29:0] w_req_idx;
  logic        w_req_ok;
  logic [31:0] w_rd_word;
  logic        w_s1_val;
  logic        w_s1_err;
  logic [31:0] w_s1_data;

  logic [29:0] w_init_idx;
  logic        w_init_ok;

  // Request decode: aligned and inside the store, otherwise an error response.
  assign w_req_idx = imem.imemreq_addr[31:2];
  assign w_req_ok  = (imem.imemreq_addr[1:0] == 2'b00) && (w_req_idx < 30'(WORDS));
  assign w_rd_word = r_store[w_req_idx[AW-1:0]];

  // Data is forced to zero for idle cycles and for error responses.
  assign w_s1_val  = imem.imemreq_val;
  assign w_s1_err  = imem.imemreq_val && !w_req_ok;
  assign w_s1_data = (imem.imemreq_val && w_req_ok) ? w_rd_word : 32'h0;

  // Preload decode: bad addresses are silently dropped.
  assign w_init_idx = imem.init_addr[31:2];
  assign w_init_ok  = imem.init_wen && (imem.init_addr[1:0] == 2'b00) &&
                      (w_init_idx < 30'(WORDS));

  // Write lands at the edge, so a same-cycle fetch of that word sees old data.
  always_ff @(posedge clk) begin
    if (rst && w_init_ok) begin
      r_store[w_init_idx[AW-1:0]] <= imem.init_data;
    end
  end

  // Response pipeline: stage 0 captures the read, later stages just shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val  <= '0;
      r_err  <= '0;
      r_data <= '0;
    end else begin
      r_val[0]  <= w_s1_val;
      r_err[0]  <= w_s1_err;
      r_data[0] <= w_s1_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_val[i]  <= r_val[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Counts at acceptance, error requests included; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 16'h0;
    end else if (imem.imemreq_val) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign imem.imemresp_val  = r_val[LATENCY-1];
  assign imem.imemresp_err  = r_err[LATENCY-1];
  assign imem.imemresp_data = r_data[LATENCY-1];
  assign imem.req_count     = r_count;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder at latencies 1, 3 and 4

module tb_imem_responder;
  localparam int WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_val = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        init_wen = 1'b0;
  logic [31:0] init_addr = 32'h0;
  logic [31:0] init_data = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_responder_if if_l1 ();
  imem_responder_if if_l3 ();
  imem_responder_if if_l4 ();

  assign if_l1.imemreq_val = req_val;  assign if_l1.imemreq_addr = req_addr;
  assign if_l1.init_wen = init_wen;    assign if_l1.init_addr = init_addr;  assign if_l1.init_data = init_data;
  assign if_l3.imemreq_val = req_val;  assign if_l3.imemreq_addr = req_addr;
  assign if_l3.init_wen = init_wen;    assign if_l3.init_addr = init_addr;  assign if_l3.init_data = init_data;
  assign if_l4.imemreq_val = req_val;  assign if_l4.imemreq_addr = req_addr;
  assign if_l4.init_wen = init_wen;    assign if_l4.init_addr = init_addr;  assign if_l4.init_data = init_data;

  imem_responder #(.WORDS(WORDS), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst_n), .imem(if_l1));
  imem_responder #(.WORDS(WORDS), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst_n), .imem(if_l3));
  imem_responder #(.WORDS(WORDS), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst_n), .imem(if_l4));

  // Observed response packed as {val, err, data}; index 0/1/2 = latency 1/3/4.
  logic [33:0] o_resp [3];
  logic [15:0] o_cnt  [3];
  assign o_resp[0] = {if_l1.imemresp_val, if_l1.imemresp_err, if_l1.imemresp_data};
  assign o_resp[1] = {if_l3.imemresp_val, if_l3.imemresp_err, if_l3.imemresp_data};
  assign o_resp[2] = {if_l4.imemresp_val, if_l4.imemresp_err, if_l4.imemresp_data};
  assign o_cnt[0]  = if_l1.req_count;
  assign o_cnt[1]  = if_l3.req_count;
  assign o_cnt[2]  = if_l4.req_count;

  // Reference model: store contents, accepted-request count, and the response
  // produced at each edge (ring indexed by edge number). A response issued at
  // edge N is visible after edge N+L-1.
  logic [31:0] m_store [WORDS];
  logic [15:0] m_count = 16'h0;
  logic [33:0] hist [8];
  int          cyc = 16;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic logic [33:0] exp_resp(int lat);
    return hist[(cyc - lat + 1) & 7];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 34'h0;
    m_count = 16'h0;
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic w,
                      input logic [31:0] wa, input logic [31:0] wd);
    logic [33:0] r;
    req_val = v; req_addr = a; init_wen = w; init_addr = wa; init_data = wd;
    @(posedge clk);
    cyc++;
    r = 34'h0;
    if (rst_n) begin
      if (v) begin
        m_count = m_count + 16'd1;
        if (a[1:0] != 2'b00 || a[31:2] >= WORDS) r = {2'b11, 32'h0};
        else r = {2'b10, m_store[a[31:2]]};
      end
      if (w && wa[1:0] == 2'b00 && wa[31:2] < WORDS) m_store[wa[31:2]] = wd;
    end
    hist[cyc & 7] = r;
    #1;
    req_val = 1'b0; init_wen = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_resp[d] !== 34'h0 || o_cnt[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset d=%0d got resp=%h cnt=%h exp 0/0", d, o_resp[d], o_cnt[d]);
      end
    end
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    for (int i = 0; i < WORDS; i++) step(1'b0, 32'(i) << 2, 1'b1, 32'(i) << 2, $urandom);
    step(1'b0, 0, 1'b1, 32'h00, 32'h00000013);
    step(1'b0, 0, 1'b1, 32'h04, 32'h00100093);
    step(1'b0, 0, 1'b1, 32'h08, 32'h00208113);
    step(1'b0, 0, 1'b1, 32'h0C, 32'hDEADBEEF);
    step(1'b0, 0, 1'b1, 32'h14, 32'hAAAAAAAA);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_resp[d] !== 34'h0 || o_cnt[d] !== 16'h0) begin
        errors++;
        $display("FAIL preload_quiet d=%0d got resp=%h cnt=%h exp 0/0", d, o_resp[d], o_cnt[d]);
      end
    end
  endtask

  task automatic test_stream_l1();
    logic [31:0] want [4];
    want[0] = 32'h00000013; want[1] = 32'h00100093; want[2] = 32'h00208113; want[3] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b1, 32'(i) << 2, 1'b0, 0, 0);
      else idle();
      if (i < 4) begin
        checks++;
        if (o_resp[0] !== {2'b10, want[i]}) begin
          errors++;
          $display("FAIL stream_l1 i=%0d got %h exp %h", i, o_resp[0], {2'b10, want[i]});
        end
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o_resp[d] !== exp_resp(lat_of(d))) begin
          errors++;
          $display("FAIL stream_model i=%0d d=%0d got %h exp %h", i, d, o_resp[d], exp_resp(lat_of(d)));
        end
      end
    end
    checks++;
    if (o_cnt[0] !== 16'd4) begin
      errors++;
      $display("FAIL stream_count got %0d exp 4", o_cnt[0]);
    end
  endtask

  task automatic test_gap_l3();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'hC;
    for (int i = 0; i < 9; i++) begin
      if (i < 2) step(1'b1, addrs[i], 1'b0, 0, 0);
      else if (i == 2) idle();
      else if (i < 5) step(1'b1, addrs[i-1], 1'b0, 0, 0);
      else idle();
      // Requests at steps 0,1,3,4 appear on the latency-3 output at steps 2,3,5,6.
      if (i == 4) begin
        checks++;
        if (o_resp[1] !== 34'h0) begin
          errors++;
          $display("FAIL gap_l3 got %h exp 0", o_resp[1]);
        end
      end
      if (i == 2) begin
        checks++;
        if (o_resp[1] !== {2'b10, 32'h00000013}) begin
          errors++;
          $display("FAIL gap_l3_first got %h exp %h", o_resp[1], {2'b10, 32'h00000013});
        end
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o_resp[d] !== exp_resp(lat_of(d))) begin
          errors++;
          $display("FAIL gap_model i=%0d d=%0d got %h exp %h", i, d, o_resp[d], exp_resp(lat_of(d)));
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [15:0] c0;
    c0 = m_count;
    step(1'b1, 32'h6, 1'b0, 0, 0);
    checks++;
    if (o_resp[0] !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL err_misaligned got %h exp %h", o_resp[0], {2'b11, 32'h0});
    end
    step(1'b1, 32'(WORDS * 4), 1'b0, 0, 0);
    checks++;
    if (o_resp[0] !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL err_range got %h exp %h", o_resp[0], {2'b11, 32'h0});
    end
    checks++;
    if (o_cnt[0] !== c0 + 16'd2) begin
      errors++;
      $display("FAIL err_count got %0d exp %0d", o_cnt[0], c0 + 16'd2);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      for (int d = 1; d < 3; d++) begin
        checks++;
        if (o_resp[d] !== exp_resp(lat_of(d))) begin
          errors++;
          $display("FAIL err_model i=%0d d=%0d got %h exp %h", i, d, o_resp[d], exp_resp(lat_of(d)));
        end
      end
    end
  endtask

  task automatic test_war();
    step(1'b1, 32'h14, 1'b1, 32'h14, 32'h12345678);
    checks++;
    if (o_resp[0] !== {2'b10, 32'hAAAAAAAA}) begin
      errors++;
      $display("FAIL war_old got %h exp %h", o_resp[0], {2'b10, 32'hAAAAAAAA});
    end
    step(1'b1, 32'h14, 1'b0, 0, 0);
    checks++;
    if (o_resp[0] !== {2'b10, 32'h12345678}) begin
      errors++;
      $display("FAIL war_new got %h exp %h", o_resp[0], {2'b10, 32'h12345678});
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o_resp[d] !== exp_resp(lat_of(d))) begin
          errors++;
          $display("FAIL war_model i=%0d d=%0d got %h exp %h", i, d, o_resp[d], exp_resp(lat_of(d)));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] wa;
    logic        v;
    logic        w;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: a = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
        1: a = 32'($urandom_range(WORDS, 4 * WORDS)) << 2;
        default: a = 32'($urandom_range(0, WORDS - 1)) << 2;
      endcase
      w = ($urandom_range(0, 2) == 0);
      // Words 0..7 hold the fixed program used by later tests; keep them intact.
      if ($urandom_range(0, 3) == 0) wa = 32'($urandom_range(0, WORDS - 1)) << 2 | 32'h2;
      else if ($urandom_range(0, 3) == 0 && a[31:2] >= 8 && a[31:2] < WORDS) wa = {a[31:2], 2'b00};
      else wa = 32'($urandom_range(8, WORDS + 8)) << 2;
      step(v, a, w, wa, $urandom);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o_resp[d] !== exp_resp(lat_of(d)) || o_cnt[d] !== m_count) begin
          errors++;
          $display("FAIL random i=%0d d=%0d got %h/%h exp %h/%h", i, d, o_resp[d], o_cnt[d],
                   exp_resp(lat_of(d)), m_count);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h0, 1'b0, 0, 0);
    step(1'b1, 32'h4, 1'b0, 0, 0);
    step(1'b1, 32'h8, 1'b0, 0, 0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_resp[d] !== 34'h0 || o_cnt[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_async d=%0d got %h/%h exp 0/0", d, o_resp[d], o_cnt[d]);
      end
    end
    step(1'b1, 32'hC, 1'b1, 32'h0C, 32'h0BADF00D);
    step(1'b1, 32'h0, 1'b0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o_resp[d] !== 34'h0 || o_cnt[d] !== 16'h0) begin
          errors++;
          $display("FAIL reset_drain i=%0d d=%0d got %h/%h exp 0/0", i, d, o_resp[d], o_cnt[d]);
        end
      end
    end
    step(1'b1, 32'hC, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) idle();
    checks++;
    if (o_resp[2] !== {2'b10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL reset_refetch got %h exp %h", o_resp[2], {2'b10, 32'hDEADBEEF});
    end
  endtask

  task automatic test_wrap();
    #3 rst_n = 1'b0;
    model_reset();
    #3 rst_n = 1'b1;
    idle();
    for (int i = 0; i < 65535; i++) step(1'b1, 32'h0, 1'b0, 0, 0);
    checks++;
    if (o_cnt[0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_ffff got %h exp ffff", o_cnt[0]);
    end
    step(1'b1, 32'h0, 1'b0, 0, 0);
    checks++;
    if (o_cnt[0] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero got %h exp 0000", o_cnt[0]);
    end
    step(1'b1, 32'h0, 1'b0, 0, 0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_cnt[d] !== 16'h0001 || o_cnt[d] !== m_count) begin
        errors++;
        $display("FAIL wrap_one d=%0d got %h exp 0001", d, o_cnt[d]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_preload();
    test_stream_l1();
    test_gap_l3();
    test_errors();
    test_war();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
